// File: rtl/i2s_clkgen.sv
// I2S audio clock generator: MCLK, SCLK and LRCK square waves from the system clock,
// plus lookahead strobes and the in-frame bit index for the serialiser.
module i2s_clkgen #(
   parameter int MCLK_DIV  = 8,
   parameter int SCLK_DIV  = 4,
   parameter int SLOT_BITS = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en,
   output logic                               mclk,
   output logic                               sclk,
   output logic                               lrck,
   output logic                               mclk_tick,
   output logic                               sclk_rise,
   output logic                               sclk_fall,
   output logic                               frame_start,
   output logic [$clog2(2*SLOT_BITS)-1:0]     bit_cnt
);

   localparam int MW = ($clog2(MCLK_DIV) < 1) ? 1 : $clog2(MCLK_DIV);
   localparam int SW = ($clog2(SCLK_DIV) < 1) ? 1 : $clog2(SCLK_DIV);
   localparam int BW = $clog2(2*SLOT_BITS);

   localparam logic [MW-1:0] M_LAST = MW'(MCLK_DIV - 1);
   localparam logic [MW-1:0] M_HALF = MW'(MCLK_DIV / 2);
   localparam logic [SW-1:0] S_LAST = SW'(SCLK_DIV - 1);
   localparam logic [SW-1:0] S_HALF = SW'(SCLK_DIV / 2);
   localparam logic [SW-1:0] S_RISE = SW'(SCLK_DIV / 2 - 1);
   localparam logic [BW-1:0] B_LAST = BW'(2*SLOT_BITS - 1);
   localparam logic [BW-1:0] B_SLOT = BW'(SLOT_BITS);

   if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
      $error("i2s_clkgen: MCLK_DIV must be even and >= 2");
   end
   if (SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_sclk_div
      $error("i2s_clkgen: SCLK_DIV must be even and >= 2");
   end
   if (SLOT_BITS < 1) begin : g_bad_slot_bits
      $error("i2s_clkgen: SLOT_BITS must be >= 1");
   end

   logic [MW-1:0] m_cnt, m_nxt;
   logic [SW-1:0] s_cnt, s_nxt;
   logic [BW-1:0] b_nxt;
   logic          m_last, s_last, b_last;

   assign m_last = (m_cnt == M_LAST);
   assign s_last = (s_cnt == S_LAST);
   assign b_last = (bit_cnt == B_LAST);

   // Next counter state; dropping en collapses everything back to state 0.
   always_comb begin
      m_nxt = '0;
      s_nxt = '0;
      b_nxt = '0;
      if (en) begin
         m_nxt = m_last ? '0 : m_cnt + 1'b1;
         s_nxt = s_cnt;
         b_nxt = bit_cnt;
         if (m_last)
            s_nxt = s_last ? '0 : s_cnt + 1'b1;
         if (m_last && s_last)
            b_nxt = b_last ? '0 : bit_cnt + 1'b1;
      end
   end

   // Outputs are registered from the next state so they match the counters cycle for cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt       <= '0;
         s_cnt       <= '0;
         bit_cnt     <= '0;
         mclk        <= 1'b0;
         sclk        <= 1'b0;
         lrck        <= 1'b0;
         mclk_tick   <= 1'b0;
         sclk_rise   <= 1'b0;
         sclk_fall   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         m_cnt       <= m_nxt;
         s_cnt       <= s_nxt;
         bit_cnt     <= b_nxt;
         mclk        <= (m_nxt >= M_HALF);
         sclk        <= (s_nxt >= S_HALF);
         lrck        <= (b_nxt >= B_SLOT);
         mclk_tick   <= (m_nxt == M_LAST);
         sclk_rise   <= (m_nxt == M_LAST) && (s_nxt == S_RISE);
         sclk_fall   <= (m_nxt == M_LAST) && (s_nxt == S_LAST);
         frame_start <= (m_nxt == M_LAST) && (s_nxt == S_LAST) && (b_nxt == B_LAST);
      end
   end

endmodule
